// File: rtl/gate_bist.sv
// Built-in self-test engine for single-output combinational gates: walks every
// input vector, samples the gate after a settle time and checks a truth table.
module gate_bist #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        fail_count,
  output logic [N_IN-1:0]      first_fail_vec,
  output logic                 first_fail_valid
);

  localparam int unsigned NVEC        = 2**N_IN;
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t            r_state;
  logic [NVEC-1:0]   r_exp;
  logic [3:0]        r_settle;
  logic [N_IN-1:0]   r_dut_in;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [N_IN:0]     r_fail_count;
  logic [N_IN-1:0]   r_first_fail_vec;
  logic              r_first_fail_valid;

  logic              w_mismatch;
  logic              w_last_vec;

  assign w_mismatch = (dut_out != r_exp[r_dut_in]);
  assign w_last_vec = &r_dut_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= IDLE;
      r_exp              <= '0;
      r_settle           <= '0;
      r_dut_in           <= '0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_pass             <= 1'b0;
      r_fail_count       <= '0;
      r_first_fail_vec   <= '0;
      r_first_fail_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_exp              <= expected;
            r_fail_count       <= '0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
            r_dut_in           <= '0;
            r_settle           <= '0;
            r_busy             <= 1'b1;
            r_state            <= APPLY;
          end
        end
        APPLY: begin
          if (abort) begin
            r_dut_in <= '0;
            r_busy   <= 1'b0;
            r_pass   <= 1'b0;
            r_state  <= IDLE;
          end else if (r_settle == SETTLE_LAST) begin
            r_state <= SAMPLE;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            r_dut_in <= '0;
            r_busy   <= 1'b0;
            r_pass   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            if (w_mismatch) begin
              r_fail_count <= r_fail_count + 1'b1;
              if (!r_first_fail_valid) begin
                r_first_fail_vec   <= r_dut_in;
                r_first_fail_valid <= 1'b1;
              end
            end
            // pass must account for a mismatch found in this final sample
            if (w_last_vec) begin
              r_done  <= 1'b1;
              r_pass  <= (r_fail_count == '0) && !w_mismatch;
              r_state <= DONE;
            end else begin
              r_dut_in <= r_dut_in + 1'b1;
              r_settle <= '0;
              r_state  <= APPLY;
            end
          end
        end
        DONE: begin
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_dut_in <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dut_in           = r_dut_in;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign fail_count       = r_fail_count;
  assign first_fail_vec   = r_first_fail_vec;
  assign first_fail_valid = r_first_fail_valid;

endmodule
